flag_counter: RTL and testbench
===============================

FLAG_COUNTER -- requirements
Module: flag_counter

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 4: width of the internal count register.
- S1_COUNT, 2: count value at or above which S1 is asserted.
- S2_COUNT, 3: modulus of the counter; reaching it produces an S2 pulse.
REQ-002 Parameter legality SHALL be 1 <= S1_COUNT < S2_COUNT <= 2^WIDTH; any other setting is unsupported.
REQ-003 Clk, input, 1: single system clock; all state updates on the rising edge.
REQ-004 Reset, input, 1: asynchronous, active-high reset.
REQ-005 EN, input, 1: count enable, sampled on the rising edge of Clk.
REQ-006 S1, output, 1: registered level flag, high while the count is >= S1_COUNT.
REQ-007 S2, output, 1: registered one-cycle pulse, high in the cycle following a counter wrap.
REQ-008 The block SHALL have exactly one clock (Clk) and one reset (Reset, asynchronous, active-high); no other ports exist.

Function
REQ-009 An internal unsigned count register of WIDTH bits SHALL hold values 0..S2_COUNT-1 only.
REQ-010 Rising edge, EN=1, count < S2_COUNT-1: count SHALL become count+1 and S2 SHALL be 0.
REQ-011 Rising edge, EN=1, count = S2_COUNT-1: count SHALL wrap to 0 and S2 SHALL be 1 for exactly that one cycle.
REQ-012 Rising edge, EN=0: count SHALL hold and S2 SHALL be 0.
REQ-013 S1 SHALL be registered from the next-state count: S1 <= (next_count >= S1_COUNT), so S1 and count change on the same edge.
REQ-014 Latency SHALL be 0 cycles from edge to flag: the edge that moves count to S1_COUNT also sets S1, and the edge that wraps count also sets S2 and clears S1.
REQ-015 EN toggling SHALL have no side effects beyond gating the increment; a partial count is retained across EN=0 periods.
REQ-016 Continuous EN=1 SHALL produce S2 once every S2_COUNT cycles, with S1 high for S2_COUNT-S1_COUNT cycles per period.
REQ-017 S1 and S2 SHALL both be glitch-free register outputs with no combinational path from EN.

Reset
REQ-018 Reset=1 SHALL immediately (asynchronously) force count=0, S1=0 and S2=0, independent of Clk and EN.
REQ-019 While Reset=1, all state SHALL hold at reset values and EN SHALL be ignored.
REQ-020 The first rising edge after Reset deasserts SHALL behave per REQ-010..REQ-013 from count=0.
REQ-021 Reset asserted mid-count or during an S2 pulse SHALL clear all state at once, with no pending pulse.

Verification
REQ-022 The bench SHALL cover these scenarios, using default parameters:
- Reset=1 for 3 clocks with EN toggling -> S1=0 and S2=0 throughout.
- Reset release, then EN=1 for 3 edges -> edge1 count=1 (S1=0, S2=0); edge2 count=2 (S1=1); edge3 count=0 (S1=0, S2=1); next edge with EN=0 -> S2=0.
- EN=1 for 2 edges, EN=0 for 5 edges, EN=1 for 1 edge -> S1 goes high at edge 2, stays high through the hold, then the wrap gives S2=1 and S1=0.
- EN=1 held for 9 edges -> exactly 3 S2 pulses, spaced 3 cycles apart; S1 high for 1 cycle per period.
- Reset asserted asynchronously between edges while count=2 -> S1 falls immediately, without waiting for a Clk edge.
- Reset asserted in the same cycle as an S2 pulse -> S2 falls immediately; after release, a full S2_COUNT enabled edges are needed for the next pulse.

Source files
------------

// File: rtl/flag_counter.sv
// flag_counter
//
// Modulo-S2_COUNT event counter with two registered status flags.
//
// Parameters:
//   WIDTH    - width of the internal count register
//   S1_COUNT - count value at or above which S1 is asserted
//   S2_COUNT - counter modulus; the wrap from S2_COUNT-1 to 0 raises S2 for one cycle
//   Supported range: 1 <= S1_COUNT < S2_COUNT <= 2**WIDTH.
//
// Ports:
//   Clk   - system clock, all state updates on the rising edge
//   Reset - asynchronous, active-high reset; clears count, S1 and S2 at once
//   EN    - count enable, sampled on the rising edge of Clk
//   S1    - registered level flag, high while count >= S1_COUNT
//   S2    - registered one-cycle pulse, high in the cycle following a wrap
module flag_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned S1_COUNT = 2,
    parameter int unsigned S2_COUNT = 3
) (
    input  logic Clk,
    input  logic Reset,
    input  logic EN,
    output logic S1,
    output logic S2
);

    // S2_COUNT may equal 2**WIDTH, so the last value is formed before truncation.
    localparam logic [WIDTH-1:0] LastCount = WIDTH'(S2_COUNT - 1);
    localparam logic [WIDTH-1:0] S1Thresh  = WIDTH'(S1_COUNT);

    logic [WIDTH-1:0] count_d, count_q;
    logic             s1_d, s1_q;
    logic             s2_d, s2_q;

    always_comb begin
        count_d = count_q;
        s2_d    = 1'b0;
        if (EN) begin
            if (count_q == LastCount) begin
                count_d = '0;
                s2_d    = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
        // Flag is taken from the next count so it moves on the same edge as the count.
        s1_d = (count_d >= S1Thresh);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    assign S1 = s1_q;
    assign S2 = s2_q;

endmodule

// File: tb/tb_flag_counter.sv
// Directed bench for flag_counter with default parameters (S1_COUNT=2, S2_COUNT=3).
module tb_flag_counter;

    logic Clk;
    logic Reset;
    logic EN;
    logic S1;
    logic S2;

    int total  = 0;
    int passed = 0;

    flag_counter dut (
        .Clk   (Clk),
        .Reset (Reset),
        .EN    (EN),
        .S1    (S1),
        .S2    (S2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive EN on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic en);
        @(negedge Clk);
        EN = en;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int pulses;
        int last_pulse;
        Reset = 1'b1;
        EN    = 1'b0;

        // Reset held for 3 clocks with EN toggling
        for (int i = 0; i < 3; i++) begin
            step(i[0] ? 1'b0 : 1'b1);
            check("rst_hold_s1", S1, 1'b0);
            check("rst_hold_s2", S2, 1'b0);
        end

        // Release, then 3 enabled edges and one idle edge
        @(negedge Clk);
        Reset = 1'b0;
        EN    = 1'b0;
        step(1'b1);
        check("e1_s1", S1, 1'b0);
        check("e1_s2", S2, 1'b0);
        step(1'b1);
        check("e2_s1", S1, 1'b1);
        check("e2_s2", S2, 1'b0);
        step(1'b1);
        check("e3_s1", S1, 1'b0);
        check("e3_s2", S2, 1'b1);
        step(1'b0);
        check("e4_s1", S1, 1'b0);
        check("e4_s2", S2, 1'b0);

        // Partial count retained across an EN=0 stretch
        step(1'b1);
        check("h1_s1", S1, 1'b0);
        step(1'b1);
        check("h2_s1", S1, 1'b1);
        check("h2_s2", S2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            check("hold_s1", S1, 1'b1);
            check("hold_s2", S2, 1'b0);
        end
        step(1'b1);
        check("hwrap_s1", S1, 1'b0);
        check("hwrap_s2", S2, 1'b1);

        // Continuous enable for 9 edges from count 0
        pulses     = 0;
        last_pulse = 0;
        for (int k = 1; k <= 9; k++) begin
            step(1'b1);
            check("run_s1", S1, (k % 3) == 2);
            check("run_s2", S2, (k % 3) == 0);
            if (S2 === 1'b1) begin
                if (pulses > 0) check_int("run_spacing", k - last_pulse, 3);
                pulses++;
                last_pulse = k;
            end
        end
        check_int("run_pulses", pulses, 3);

        // Asynchronous reset mid-cycle with count=2
        step(1'b1);
        step(1'b1);
        check("pre_ar_s1", S1, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("ar_s1", S1, 1'b0);
        check("ar_s2", S2, 1'b0);
        step(1'b1);
        check("ar_en_ign_s1", S1, 1'b0);
        check("ar_en_ign_s2", S2, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        EN    = 1'b0;

        // Reset during an S2 pulse
        step(1'b1);
        check("p1_s1", S1, 1'b0);
        step(1'b1);
        check("p2_s1", S1, 1'b1);
        step(1'b1);
        check("p3_s2", S2, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("pr_s2", S2, 1'b0);
        check("pr_s1", S1, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        EN    = 1'b0;
        step(1'b1);
        check("q1_s1", S1, 1'b0);
        check("q1_s2", S2, 1'b0);
        step(1'b1);
        check("q2_s1", S1, 1'b1);
        check("q2_s2", S2, 1'b0);
        step(1'b1);
        check("q3_s1", S1, 1'b0);
        check("q3_s2", S2, 1'b1);
        step(1'b0);
        check("q4_s2", S2, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
